connectnet_arbiter: RTL and testbench

- Round-robin, burst-locking arbiter that shares one point-to-point net link among NUM_REQ requesters.
- Each requester presents valid/ready/data/last beats. The arbiter grants one requester at a time and holds the grant until its last beat.
- Beats are forwarded through a single registered output stage onto the shared net.
- Sits between multiple producer portals and a net pass-through instance.

---
 rtl/connectnet_arbiter.sv | 150 +++++++++++++++
 tb/tb_connectnet_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/connectnet_arbiter.sv
// rtl/connectnet_arbiter.sv - round-robin burst-locking arbiter onto one registered net link
// Optional stall timeout: define CONNECTNET_ARB_TIMEOUT_EN.
module connectnet_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [IDW-1:0]                grant_id,
  output logic                          grant_active,
  output logic                          timeout_err
);

  if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
    $error("connectnet_arbiter: NUM_REQ must be 1..16");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("connectnet_arbiter: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [IDW-1:0]        rr_ptr, rr_next, grant_next, pick, grant_inc;
  logic [IDW:0]          cand;
  logic                  found, can_accept, xfer, stall_hit;
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;

  // Scan requesters in cyclic order starting at rr_ptr; first valid wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (cand[IDW-1:0] == IDW'(i))) begin
          found = 1'b1;
          pick  = IDW'(i);
        end
      end
    end
  end

  assign can_accept   = !out_valid || out_ready;
  assign grant_active = (state == LOCKED);
  assign grant_inc    = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_data    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        g_valid      = req_valid[i];
        g_last       = req_last[i];
        g_data       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = grant_active && can_accept;
      end
    end
  end

  assign xfer = grant_active && g_valid && can_accept;

`ifdef CONNECTNET_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;

  assign stall_hit = grant_active && !xfer && (stall_cnt == 16'(TIMEOUT_CYCLES-1));

  // Counter sits at zero outside LOCKED, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= stall_hit;
      if (!grant_active || xfer || stall_hit) stall_cnt <= '0;
      else                                    stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    grant_next = grant_id;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = LOCKED;
          grant_next = pick;
        end
      end
      LOCKED: begin
        if ((xfer && g_last) || stall_hit) begin
          state_next = IDLE;
          rr_next    = grant_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_next;
      grant_id <= grant_next;
    end
  end

  // Load wins over drain so back-to-back beats keep out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_last  <= g_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_connectnet_arbiter.sv
// tb/tb_connectnet_arbiter.sv - directed scoreboard bench for connectnet_arbiter
module tb_connectnet_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_last, out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      grant_id;
  logic            grant_active, timeout_err;

  always #5 clk = ~clk;

  connectnet_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .grant_active(grant_active), .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] bd[N][16];
  logic          bl[N][16];
  int            bn[N];
  int            bp[N];
  logic          hold[N];
  logic [DW:0]   sb[$];
  logic [1:0]    glog[$];
  int            gcyc[$];
  logic          prev_ga = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [DW-1:0] d, input logic l);
    if (bp[i] == bn[i]) begin
      bp[i] = 0;
      bn[i] = 0;
    end
    bd[i][bn[i]] = d;
    bl[i][bn[i]] = l;
    bn[i]++;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      if (bp[i] < bn[i] && !hold[i]) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = bl[i][bp[i]];
        req_data[i*DW +: DW] = bd[i][bp[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic flush();
    sb.delete();
    for (int i = 0; i < N; i++) begin
      bn[i]   = 0;
      bp[i]   = 0;
      hold[i] = 1'b0;
    end
    apply();
  endtask

  // One clock: expected beats are queued for whatever the DUT will accept this edge.
  task automatic cycle();
    logic [N-1:0] acc;
    apply();
    #1;
    acc = req_valid & req_ready;
    for (int i = 0; i < N; i++)
      if (acc[i]) sb.push_back({bl[i][bp[i]], bd[i][bp[i]]});
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (acc[i]) bp[i]++;
    if (grant_active && !prev_ga) begin
      glog.push_back(grant_id);
      gcyc.push_back(cyc);
    end
    prev_ga = grant_active;
    apply();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(pd));
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) check("beat", 64'({out_last, out_data}), 64'(sb.pop_front()));
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] gexp[5];
    int n;
    int bad;
    gexp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    out_ready = 1'b1;
    flush();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 64'({out_valid, out_last, out_data}), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_active", 64'(grant_active), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_timeout", 64'(timeout_err), 64'(0));
    rst_n = 1'b1;

    // Requesters 1 and 3; burst of three from 1, then 3
    load(1, 32'hA1, 1'b0); load(1, 32'hA2, 1'b0); load(1, 32'hA3, 1'b1);
    load(3, 32'hB1, 1'b1);
    cycle();
    check("t1_grant1", 64'({grant_active, grant_id}), 64'({1'b1, 2'd1}));
    cycle();
    check("t1_beat_a1", 64'({out_valid, out_last, out_data}), 64'({2'b10, 32'hA1}));
    cycle();
    check("t1_beat_a2", 64'({out_valid, out_last, out_data}), 64'({2'b10, 32'hA2}));
    cycle();
    check("t1_beat_a3", 64'({out_valid, out_last, out_data}), 64'({2'b11, 32'hA3}));
    check("t1_idle", 64'(grant_active), 64'(0));
    cycle();
    check("t1_grant3", 64'({grant_active, grant_id}), 64'({1'b1, 2'd3}));
    run(3);

    // All four requesting, 2-beat bursts: order wraps back to 0, 3 cycles per burst
    glog.delete();
    gcyc.delete();
    load(0, 32'h10, 1'b0); load(0, 32'h11, 1'b1); load(0, 32'h14, 1'b0); load(0, 32'h15, 1'b1);
    load(1, 32'h20, 1'b0); load(1, 32'h21, 1'b1);
    load(2, 32'h30, 1'b0); load(2, 32'h31, 1'b1);
    load(3, 32'h40, 1'b0); load(3, 32'h41, 1'b1);
    run(17);
    check("t2_grant_count", 64'(glog.size()), 64'(5));
    for (int k = 0; k < glog.size() && k < 5; k++) begin
      check("t2_grant_order", 64'(glog[k]), 64'(gexp[k]));
      if (k > 0) check("t2_burst_cycles", 64'(gcyc[k] - gcyc[k-1]), 64'(3));
    end

    // Backpressure mid-burst on requester 1
    for (int b = 0; b < 6; b++) load(1, 32'h50 + 32'(b), b == 5);
    run(3);
    out_ready = 1'b0;
    #1;
    check("t3_ready_low", 64'(req_ready), 64'(0));
    run(5);
    check("t3_held", 64'({out_valid, out_last, out_data}), 64'({2'b10, 32'h51}));
    check("t3_ready_still_low", 64'(req_ready), 64'(0));
    out_ready = 1'b1;
    run(4);
    check("t3_full_rate", 64'({out_valid, out_last, out_data}), 64'({2'b11, 32'h55}));
    check("t3_released", 64'(grant_active), 64'(0));
    run(2);

    // Granted requester 2 drops valid for 4 cycles while 0 and 3 wait
    for (int b = 0; b < 4; b++) load(2, 32'h60 + 32'(b), b == 3);
    load(0, 32'h70, 1'b1);
    load(3, 32'h80, 1'b1);
    run(3);
    check("t4_grant2", 64'({grant_active, grant_id}), 64'({1'b1, 2'd2}));
    hold[2] = 1'b1;
    repeat (4) begin
      cycle();
      check("t4_lock_held", 64'({grant_active, grant_id}), 64'({1'b1, 2'd2}));
      check("t4_others_blocked", 64'(req_ready & 4'b1011), 64'(0));
    end
    hold[2] = 1'b0;
    run(10);
    check("t4_drained", 64'(sb.size()), 64'(0));

    // Reset mid-burst with out_valid high
    for (int b = 0; b < 4; b++) load(1, 32'h90 + 32'(b), b == 3);
    run(3);
    check("t5_pre_reset", 64'({out_valid, out_data}), 64'({1'b1, 32'h91}));
    rst_n = 1'b0;
    #1;
    check("t5_async_out", 64'({out_valid, out_last, out_data}), 64'(0));
    check("t5_async_grant", 64'({grant_active, grant_id}), 64'(0));
    flush();
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    prev_ga = 1'b0;
    load(2, 32'hC0, 1'b1);
    cycle();
    check("t5_grant2", 64'({grant_active, grant_id}), 64'({1'b1, 2'd2}));
    run(3);
    check("t5_drained", 64'(sb.size()), 64'(0));

    // Requester 0 stalls while locked
    rst_n = 1'b0;
    flush();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    prev_ga = 1'b0;
    load(0, 32'hD0, 1'b1);
    load(1, 32'hE0, 1'b1);
    cycle();
    check("t6_grant0", 64'({grant_active, grant_id}), 64'({1'b1, 2'd0}));
    hold[0] = 1'b1;
`ifdef CONNECTNET_ARB_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 40) begin
      cycle();
      n++;
    end
    check("t6_timeout_pulse", 64'(timeout_err), 64'(1));
    cycle();
    check("t6_pulse_width", 64'(timeout_err), 64'(0));
    check("t6_next_grant", 64'({grant_active, grant_id}), 64'({1'b1, 2'd1}));
`else
    bad = 0;
    n   = 0;
    repeat (100) begin
      cycle();
      if (timeout_err || !grant_active || grant_id != 2'd0) bad++;
    end
    check("t6_lock_held_100", 64'(bad), 64'(0));
`endif
    rst_n = 1'b0;
    flush();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
